// File: rtl/ps2_kbd_rx.sv
// Host-side PS/2 keyboard receiver: sync/filter, 11-bit deframing, parity/stop check, key events.
// Define PS2_RX_PREFIX_EN to fold E0/F0 prefixes into key_ext/key_release.
module ps2_kbd_rx #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 12000,
   parameter int unsigned TMO_W      = 14
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       rx_err,
   output logic       busy,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       key_strobe
);

   localparam int unsigned FLT_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t              state_q, state_d;
   logic                clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic                dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic                filt_clk_q, filt_clk_d;
   logic [FLT_W-1:0]    flt_cnt_q, flt_cnt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
   logic [BYTE_W-1:0]   shift_q, shift_d;
   logic                parity_q, parity_d;
   logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
   logic                rx_strobe_q, rx_strobe_d;
   logic                rx_err_q, rx_err_d;
   logic                busy_q, busy_d;
   logic [BYTE_W-1:0]   key_code_q, key_code_d;
   logic                key_strobe_q, key_strobe_d;
   logic                fall_c;
`ifdef PS2_RX_PREFIX_EN
   logic                ext_q, ext_d, rel_q, rel_d;
   logic                key_ext_q, key_ext_d, key_rel_q, key_rel_d;
`endif

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         clk_s1_q     <= 1'b1;
         clk_s2_q     <= 1'b1;
         dat_s1_q     <= 1'b1;
         dat_s2_q     <= 1'b1;
         filt_clk_q   <= 1'b1;
         flt_cnt_q    <= '0;
         tmo_q        <= '0;
         bitcnt_q     <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         rx_byte_q    <= '0;
         rx_strobe_q  <= 1'b0;
         rx_err_q     <= 1'b0;
         busy_q       <= 1'b0;
         key_code_q   <= '0;
         key_strobe_q <= 1'b0;
`ifdef PS2_RX_PREFIX_EN
         ext_q        <= 1'b0;
         rel_q        <= 1'b0;
         key_ext_q    <= 1'b0;
         key_rel_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         clk_s1_q     <= clk_s1_d;
         clk_s2_q     <= clk_s2_d;
         dat_s1_q     <= dat_s1_d;
         dat_s2_q     <= dat_s2_d;
         filt_clk_q   <= filt_clk_d;
         flt_cnt_q    <= flt_cnt_d;
         tmo_q        <= tmo_d;
         bitcnt_q     <= bitcnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         rx_byte_q    <= rx_byte_d;
         rx_strobe_q  <= rx_strobe_d;
         rx_err_q     <= rx_err_d;
         busy_q       <= busy_d;
         key_code_q   <= key_code_d;
         key_strobe_q <= key_strobe_d;
`ifdef PS2_RX_PREFIX_EN
         ext_q        <= ext_d;
         rel_q        <= rel_d;
         key_ext_q    <= key_ext_d;
         key_rel_q    <= key_rel_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      filt_clk_d   = filt_clk_q;
      flt_cnt_d    = '0;
      bitcnt_d     = bitcnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      rx_byte_d    = rx_byte_q;
      rx_strobe_d  = 1'b0;
      rx_err_d     = 1'b0;
      key_code_d   = key_code_q;
      key_strobe_d = 1'b0;
`ifdef PS2_RX_PREFIX_EN
      ext_d        = ext_q;
      rel_d        = rel_q;
      key_ext_d    = key_ext_q;
      key_rel_d    = key_rel_q;
`endif

      clk_s1_d = ps2_clk_i;
      clk_s2_d = clk_s1_q;
      dat_s1_d = ps2_dat_i;
      dat_s2_d = dat_s1_q;

      // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
      if (clk_s2_q != filt_clk_q) begin
         if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
            filt_clk_d = clk_s2_q;
         end else begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
         end
      end
      fall_c = filt_clk_q & ~filt_clk_d;

      if ((state_q == S_IDLE) || fall_c) tmo_d = '0;
      else                               tmo_d = tmo_q + TMO_W'(1);

      case (state_q)
         S_IDLE: begin
            if (fall_c && !dat_s2_q) begin
               state_d  = S_DATA;
               bitcnt_d = '0;
               shift_d  = '0;
            end
         end
         S_DATA: begin
            if (fall_c) begin
               shift_d[bitcnt_q] = dat_s2_q;
               if (bitcnt_q == CNT_W'(BYTE_W - 1)) state_d = S_PARITY;
               else                                bitcnt_d = bitcnt_q + CNT_W'(1);
            end
         end
         S_PARITY: begin
            if (fall_c) begin
               parity_d = dat_s2_q;
               state_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (fall_c) begin
               state_d = S_IDLE;
               if (((^shift_q) ^ parity_q) && dat_s2_q) begin
                  rx_byte_d   = shift_q;
                  rx_strobe_d = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A fall in the same cycle takes priority over the timeout
      if ((state_q != S_IDLE) && !fall_c && (tmo_q == TMO_W'(TIMEOUT))) begin
         state_d  = S_IDLE;
         rx_err_d = 1'b1;
      end

      busy_d = (state_d != S_IDLE);

`ifdef PS2_RX_PREFIX_EN
      if (rx_err_q) begin
         ext_d = 1'b0;
         rel_d = 1'b0;
      end else if (rx_strobe_q) begin
         if (rx_byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (rx_byte_q == 8'hF0) begin
            rel_d = 1'b1;
         end else begin
            key_code_d   = rx_byte_q;
            key_ext_d    = ext_q;
            key_rel_d    = rel_q;
            key_strobe_d = 1'b1;
            ext_d        = 1'b0;
            rel_d        = 1'b0;
         end
      end
`else
      if (rx_strobe_q) begin
         key_code_d   = rx_byte_q;
         key_strobe_d = 1'b1;
      end
`endif
   end

   assign rx_byte    = rx_byte_q;
   assign rx_strobe  = rx_strobe_q;
   assign rx_err     = rx_err_q;
   assign busy       = busy_q;
   assign key_code   = key_code_q;
   assign key_strobe = key_strobe_q;
`ifdef PS2_RX_PREFIX_EN
   assign key_ext     = key_ext_q;
   assign key_release = key_rel_q;
`else
   assign key_ext     = 1'b0;
   assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: randomized PS/2 frames against a frame-level reference model.
// Honours PS2_RX_PREFIX_EN in its model when the design is built with it.
module tb_ps2_kbd_rx;
   localparam int unsigned FILTER_LEN = 8;
   localparam int unsigned TIMEOUT    = 1000;
   localparam int unsigned TMO_W      = 14;
   localparam int unsigned HALF       = 40;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk_i = 1'b1;
   logic       ps2_dat_i = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_strobe, rx_err, busy;
   logic [7:0] key_code;
   logic       key_ext, key_release, key_strobe;

   ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
      .clk_sys(clk_sys), .reset(reset), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
      .rx_byte(rx_byte), .rx_strobe(rx_strobe), .rx_err(rx_err), .busy(busy),
      .key_code(key_code), .key_ext(key_ext), .key_release(key_release), .key_strobe(key_strobe)
   );

   always #5 clk_sys = ~clk_sys;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         last_rx_cyc = -100;
   logic [8:0] exp_rx_q[$];   // {good, byte shown on rx_byte}
   logic [9:0] exp_key_q[$];  // {release, ext, code}
   logic [8:0] mon_rx;
   logic [9:0] mon_key;
   logic [7:0] m_last_good = 8'h00;
   logic       m_ext = 1'b0;
   logic       m_rel = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected event (t=%0t)", name, $time);
   endtask

   // Frame-level reference: odd parity over data+parity, stop must be 1
   task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
      bit good;
      good = ((($countones(b) + int'(par)) % 2) == 1) && (stp == 1'b1);
      if (good) begin
         m_last_good = b;
         exp_rx_q.push_back({1'b1, b});
`ifdef PS2_RX_PREFIX_EN
         if (b == 8'hE0)      m_ext = 1'b1;
         else if (b == 8'hF0) m_rel = 1'b1;
         else begin
            exp_key_q.push_back({m_rel, m_ext, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
         end
`else
         exp_key_q.push_back({2'b00, b});
`endif
      end else begin
         model_error();
      end
   endtask

   task automatic model_error();
      exp_rx_q.push_back({1'b0, m_last_good});
      m_ext = 1'b0;
      m_rel = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat_i = b;
      wait_cyc(HALF);
      ps2_clk_i = 1'b0;
      wait_cyc(HALF);
      ps2_clk_i = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
      model_frame(b, par, stp);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      ps2_bit(stp);
      ps2_dat_i = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ($countones(b) % 2) == 0;
   endfunction

   // Monitor: pop the scoreboard whenever the DUT presents an event
   always @(negedge clk_sys) begin
      cyc++;
      if (!reset) begin
         if (rx_strobe && rx_err) fail_now("rx_strobe_with_rx_err");
         if (key_strobe) begin
            if (exp_key_q.size() == 0) fail_now("key_strobe_unexpected");
            else begin
               mon_key = exp_key_q.pop_front();
               check("key_code", int'(key_code), int'(mon_key[7:0]));
               check("key_ext", int'(key_ext), int'(mon_key[8]));
               check("key_release", int'(key_release), int'(mon_key[9]));
            end
            check("key_latency", cyc - last_rx_cyc, 1);
         end
         if (rx_strobe || rx_err) begin
            if (exp_rx_q.size() == 0) fail_now("rx_event_unexpected");
            else begin
               mon_rx = exp_rx_q.pop_front();
               check("rx_kind_good", int'(rx_strobe), int'(mon_rx[8]));
               check("rx_byte", int'(rx_byte), int'(mon_rx[7:0]));
            end
         end
         if (rx_strobe) last_rx_cyc = cyc;
      end
   end

   initial begin
      logic [7:0] b;
      logic       par, stp;
      wait_cyc(3);
      @(negedge clk_sys);
      check("reset_rx_byte", int'(rx_byte), 0);
      check("reset_strobes", int'({rx_strobe, rx_err, key_strobe}), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_key", int'({key_code, key_ext, key_release}), 0);
      wait_cyc(1);
      reset = 1'b0;
      wait_cyc(20);

      send_frame(8'h1C, 1'b0, 1'b1);
      check("busy_after_good", int'(busy), 0);
      send_frame(8'h1C, 1'b1, 1'b1);
      check("busy_after_parity_err", int'(busy), 0);
      send_frame(8'h33, odd_par(8'h33), 1'b0);
      check("busy_after_stop_err", int'(busy), 0);

      send_frame(8'hE0, odd_par(8'hE0), 1'b1);
      send_frame(8'hF0, odd_par(8'hF0), 1'b1);
      send_frame(8'h75, odd_par(8'h75), 1'b1);

      // Partial frame, then silence past the timeout
      model_error();
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
      ps2_dat_i = 1'b1;
      check("busy_mid_frame", int'(busy), 1);
      wait_cyc(int'(TIMEOUT) + 60);
      check("busy_after_timeout", int'(busy), 0);
      send_frame(8'h29, odd_par(8'h29), 1'b1);

      // Short low glitches with data low must not start a frame
      for (int g = FILTER_LEN - 2; g <= FILTER_LEN - 1; g++) begin
         ps2_dat_i = 1'b0;
         wait_cyc(5);
         ps2_clk_i = 1'b0;
         wait_cyc(g);
         ps2_clk_i = 1'b1;
         wait_cyc(20);
         check("busy_after_glitch", int'(busy), 0);
         ps2_dat_i = 1'b1;
         wait_cyc(10);
      end

      // Reset in the middle of a frame
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1);
      check("busy_before_reset", int'(busy), 1);
      reset = 1'b1;
      wait_cyc(2);
      @(negedge clk_sys);
      check("inreset_rx_byte", int'(rx_byte), 0);
      check("inreset_busy", int'(busy), 0);
      check("inreset_key", int'({key_code, key_ext, key_release, key_strobe}), 0);
      wait_cyc(1);
      ps2_dat_i = 1'b1;
      reset = 1'b0;
      m_last_good = 8'h00;
      m_ext = 1'b0;
      m_rel = 1'b0;
      wait_cyc(20);
      send_frame(8'h5A, odd_par(8'h5A), 1'b1);

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 9))
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            default: b = 8'($urandom);
         endcase
         par = odd_par(b);
         if ($urandom_range(0, 4) == 0) par = ~par;
         stp = ($urandom_range(0, 9) != 0);
         send_frame(b, par, stp);
      end

      for (int i = 0; i < 500 && (exp_rx_q.size() + exp_key_q.size()) > 0; i++) wait_cyc(1);
      check("rx_queue_drained", exp_rx_q.size(), 0);
      check("key_queue_drained", exp_key_q.size(), 0);
      check("final_busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
